// File: rtl/raw_buffer_ctrl.sv
// raw_buffer_ctrl: acquisition sequencer for one antenna capture buffer feeding the FFT.
//
// Each acquisition pulses the buffer reset, waits for the buffer to report full,
// passes the FFT's ready through to the buffer's source side, and counts RUNS
// completed output batches before reporting done.
// Runs entirely in the source (FFT) clock domain. buf_ready comes from the sink
// domain and is brought in through a two-flop synchronizer.
//
// Optional feature: define RAW_BUFFER_CTRL_AUTO_REARM_EN so that a finished
// acquisition rearms itself (DONE -> RST) until abort, instead of returning to IDLE.
//
// Ports:
//   source_clk        clock, FFT/output domain
//   reset             synchronous active-high reset
//   start             pulse, begins an acquisition (IDLE only)
//   abort             pulse, ends the acquisition and returns to IDLE
//   buf_reset         reset to the capture buffer
//   buf_ready         buffer-full flag (asynchronous to source_clk)
//   buf_valid/sop/eop buffer source-side framing
//   fft_ready         downstream ready
//   buf_source_ready  ready to the buffer, fft_ready gated by STREAM
//   busy              any state except IDLE
//   done              one-cycle completion pulse
//   error             sticky; cleared by an accepted start or reset
//   batch_count       batches completed in this acquisition
module raw_buffer_ctrl #(
  parameter int RUNS         = 4,
  parameter int RESET_CYCLES = 4,
  parameter int FILL_TIMEOUT = 8192
) (
  input  logic                       source_clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  output logic                       buf_reset,
  input  logic                       buf_ready,
  input  logic                       buf_valid,
  input  logic                       buf_sop,
  input  logic                       buf_eop,
  input  logic                       fft_ready,
  output logic                       buf_source_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [$clog2(RUNS+1)-1:0]  batch_count
);

  localparam int BW    = $clog2(RUNS + 1);
  localparam int CMAX  = (FILL_TIMEOUT > RESET_CYCLES) ? FILL_TIMEOUT : RESET_CYCLES;
  localparam int CW    = $clog2(CMAX + 1);

  localparam logic [BW-1:0] RUNS_B    = BW'(RUNS);
  localparam logic [CW-1:0] RST_LOAD  = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] FILL_LAST = CW'(FILL_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_FILL,
    S_STREAM,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;        // RST hold countdown, then FILL timeout count
  logic            armed_q, armed_d;    // rdy_s seen low since entering FILL
  logic            open_q, open_d;      // sop seen, eop not yet seen
  logic            error_d;
  logic [BW-1:0]   count_d, count_inc;
  logic            rdy_meta, rdy_s;
  logic            proto_err;

  // Saturating increment; the counter must never wrap past RUNS.
  assign count_inc = (batch_count == RUNS_B) ? batch_count : batch_count + 1'b1;

  // NOTE: combinational blocks use blocking '=' and assign every output a default
  // at the top, so no path can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    armed_d          = armed_q;
    open_d           = open_q;
    error_d          = error;
    count_d          = batch_count;
    proto_err        = 1'b0;
    buf_reset        = 1'b0;
    buf_source_ready = 1'b0;
    busy             = (state_q != S_IDLE);
    done             = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort wins over a simultaneous start.
        if (start && !abort) begin
          state_d = S_RST;
          cnt_d   = RST_LOAD;
          error_d = 1'b0;
          count_d = '0;
        end
      end

      S_RST: begin
        buf_reset = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_FILL;
          cnt_d   = '0;
          armed_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_FILL: begin
        // A ready flag still high from the previous acquisition is stale; only
        // a rising flag after at least one low sample means this fill is done.
        if (!rdy_s) armed_d = 1'b1;
        if (armed_q && rdy_s) begin
          state_d = S_STREAM;
          open_d  = 1'b0;
        end else if (cnt_q == FILL_LAST) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STREAM: begin
        buf_source_ready = fft_ready;
        if (buf_valid) begin
          if (buf_sop && open_q)                proto_err = 1'b1;
          if (buf_eop && !buf_sop && !open_q)   proto_err = 1'b1;
          if (buf_eop)      open_d = 1'b0;
          else if (buf_sop) open_d = 1'b1;
        end
        if (proto_err || !rdy_s) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end else if (buf_valid && buf_eop) begin
          count_d = count_inc;
          if (count_inc == RUNS_B) state_d = S_DONE;
        end
      end

      S_DONE: begin
        done = 1'b1;
`ifdef RAW_BUFFER_CTRL_AUTO_REARM_EN
        state_d = S_RST;
        cnt_d   = RST_LOAD;
        count_d = '0;
`else
        state_d = S_IDLE;
`endif
      end

      default: state_d = S_IDLE;
    endcase

    // Abort discards whatever this cycle would have done; error and count hold.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      error_d = error;
      count_d = batch_count;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge source_clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      armed_q     <= 1'b0;
      open_q      <= 1'b0;
      error       <= 1'b0;
      batch_count <= '0;
      rdy_meta    <= 1'b0;
      rdy_s       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      open_q      <= open_d;
      error       <= error_d;
      batch_count <= count_d;
      rdy_meta    <= buf_ready;
      rdy_s       <= rdy_meta;
    end
  end

endmodule

// File: doc/raw_buffer_ctrl.md
Name: raw_buffer_ctrl

Overview:
- Single-clock sequencer for one antenna capture buffer feeding the FFT.
- Each acquisition cycle: pulses the buffer reset, waits for the buffer to report full, gates the FFT's ready into the buffer's source side, and counts RUNS completed output batches.
- Reports busy, done and error status to the system controller.
- Runs in the source (FFT) clock domain. Synchronizes the buffer's ready flag, which is produced in the sink domain.

Parameters:
- RUNS, 4, output batches expected per acquisition; must match the buffer's RUNS.
- RESET_CYCLES, 4, cycles buf_reset is held high; minimum 3.
- FILL_TIMEOUT, 8192, max cycles in FILL before error; must exceed the buffer's fill time in source_clk cycles.

Ports:
- source_clk  in  1  clock, FFT/output domain
- reset  in  1  synchronous active-high reset
- start  in  1  pulse: begin acquisition; ignored unless IDLE
- abort  in  1  pulse: terminate acquisition
- buf_reset  out  1  drives buffer reset
- buf_ready  in  1  buffer full flag (sink domain, asynchronous here)
- buf_valid  in  1  buffer source_valid
- buf_sop  in  1  buffer source_sop
- buf_eop  in  1  buffer source_eop
- fft_ready  in  1  downstream ready
- buf_source_ready  out  1  gated ready to buffer
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on completion
- error  out  1  sticky; cleared by accepted start or reset
- batch_count  out  $clog2(RUNS+1)  completed batches this acquisition

Behaviour:
- Reset values: buf_reset=0, buf_source_ready=0, busy=0, done=0, error=0, batch_count=0, state=IDLE, ready synchronizer flops=0.
- Synchronizer: buf_ready passes through 2 flops giving rdy_s; 2-cycle latency. Only rdy_s is used internally.
- States: IDLE, RST, FILL, STREAM, DONE.
- IDLE:
  - buf_source_ready=0.
  - start=1 -> RST; on the same edge clear error and batch_count, load the cycle counter.
- RST:
  - buf_reset=1 for exactly RESET_CYCLES cycles, then -> FILL.
- FILL:
  - buf_reset=0, buf_source_ready=0, timeout counter runs.
  - Ignore rdy_s until it has been sampled 0 at least once since entering FILL; this rejects the stale ready flag from the previous acquisition.
  - Armed and rdy_s=1 -> STREAM.
  - Counter reaches FILL_TIMEOUT -> error=1, -> IDLE.
- STREAM:
  - buf_source_ready = fft_ready, combinational passthrough.
  - Each cycle with buf_valid & buf_eop: batch_count+1.
  - The eop that brings batch_count to RUNS -> DONE. buf_source_ready is forced 0 from the next cycle onward.
  - Protocol check, each violation sets error=1 and -> IDLE:
    - buf_valid & buf_sop while a batch is open (sop seen, eop not yet seen);
    - buf_valid & buf_eop with no open batch.
  - A single-entry batch (sop & eop together) is legal.
  - rdy_s falling to 0 -> error=1, -> IDLE.
- DONE: done=1 for one cycle, -> IDLE (see optional feature).
- abort (any state except IDLE):
  - -> IDLE next cycle; buf_source_ready=0 from that cycle; no done pulse; error unchanged.
  - abort and start in the same cycle: abort wins.
- start outside IDLE: ignored.
- batch_count holds its value in IDLE until the next accepted start.
- batch_count saturates at RUNS and never wraps.
- buf_valid/sop/eop are ignored outside STREAM.
- reset mid-operation: all outputs return to reset values on the next edge, including buf_reset=0.

Optional Feature:
- Macro: RAW_BUFFER_CTRL_AUTO_REARM_EN.
- Defined:
  - DONE -> RST directly, giving continuous acquisition until abort; done still pulses each cycle of completion.
  - batch_count clears on re-entering RST.
  - busy stays 1 throughout.
- Undefined: DONE -> IDLE; each acquisition needs a new start.

Test Plan:
- Nominal: RUNS=4, RESET_CYCLES=4. start at cycle 10 -> buf_reset high cycles 11–14. buf_ready rises 100 cycles later -> STREAM 2 cycles after the rise. 4 eops -> batch_count=4, done one cycle, busy falls, buf_source_ready 0 after the 4th eop.
- Backpressure: fft_ready toggles 1/0 every cycle in STREAM -> buf_source_ready mirrors it exactly. No extra batch_count increments.
- Timeout: FILL_TIMEOUT=64, buf_ready held 0 -> error=1 after 64 FILL cycles, IDLE. A subsequent start clears error.
- Stale ready: buf_ready held 1 through RST -> no STREAM entry until buf_ready goes 0 then 1 again.
- Abort/protocol: abort in STREAM after 2 eops -> IDLE, no done, batch_count=2. Separate run: sop twice without eop -> error=1. start+abort in the same cycle from IDLE -> stays IDLE.
- Auto-rearm (macro defined): 3 consecutive acquisitions -> 3 done pulses, buf_reset pulses between them, busy never drops until abort.
